// File: rtl/commu_bridge.sv
// UART byte-protocol command engine: turns host frames into fx burst writes and reads,
// acknowledging writes and streaming read data back one byte per address.
module commu_bridge #(
   parameter int          ADDR_BYTES = 4,
   parameter int          RD_LAT     = 1,
   parameter int          TIMEOUT_US = 10000,
   parameter logic [7:0]  WR_HDR     = 8'hA5,
   parameter logic [7:0]  RD_HDR     = 8'h5A,
   localparam int         ADDR_W     = 8 * ADDR_BYTES
) (
   input  logic              clk_sys,
   input  logic              rst,
   input  logic              pluse_us,
   input  logic [7:0]        rx_data,
   input  logic              rx_vld,
   output logic [7:0]        tx_data,
   output logic              tx_vld,
   input  logic              tx_busy,
   output logic [ADDR_W-1:0] fx_waddr,
   output logic              fx_wr,
   output logic [7:0]        fx_data,
   output logic              fx_rd,
   output logic [ADDR_W-1:0] fx_raddr,
   input  logic [7:0]        fx_q,
   output logic              timeout_err,
   output logic              cmd_done
);

   localparam int         TO_W     = $clog2(TIMEOUT_US + 1);
   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WACK, S_RREQ, S_RWAIT, S_RSEND, S_NAK
   } state_t;

   state_t            state;
   logic              write_mode;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        abyte_cnt;
   logic [7:0]        remain;     // beats left after the current one (LEN byte)
   logic [TO_W-1:0]   to_cnt;
   logic [2:0]        lat_cnt;
   logic [7:0]        rd_byte;
   logic              rx_phase;
   logic              timeout_hit;
   logic              tx_ok;

   assign rx_phase    = (state == S_ADDR) || (state == S_LEN) || (state == S_WDATA);
   // The clear on rx_vld outranks a same-cycle tick, so a byte always rescues the frame.
   assign timeout_hit = rx_phase && pluse_us && !rx_vld &&
                        (to_cnt == TO_W'(TIMEOUT_US - 1));
   // tx_vld is high during the guard cycle, so tx_busy is not trusted until the PHY has seen it.
   assign tx_ok       = !tx_busy && !tx_vld;

   // NOTE: one clocked process with non-blocking updates; the reset branch is synchronous and clears every register.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state       <= S_IDLE;
         write_mode  <= 1'b0;
         addr        <= '0;
         abyte_cnt   <= '0;
         remain      <= '0;
         to_cnt      <= '0;
         lat_cnt     <= '0;
         rd_byte     <= '0;
         tx_data     <= '0;
         tx_vld      <= 1'b0;
         fx_waddr    <= '0;
         fx_wr       <= 1'b0;
         fx_data     <= '0;
         fx_rd       <= 1'b0;
         fx_raddr    <= '0;
         timeout_err <= 1'b0;
         cmd_done    <= 1'b0;
      end else begin
         tx_vld      <= 1'b0;
         fx_wr       <= 1'b0;
         fx_rd       <= 1'b0;
         timeout_err <= 1'b0;
         cmd_done    <= 1'b0;

         if (!rx_phase || rx_vld)
            to_cnt <= '0;
         else if (pluse_us)
            to_cnt <= to_cnt + 1'b1;

         if (timeout_hit) begin
            timeout_err <= 1'b1;
            state       <= S_NAK;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rx_vld && (rx_data == WR_HDR || rx_data == RD_HDR)) begin
                     write_mode <= (rx_data == WR_HDR);
                     abyte_cnt  <= '0;
                     state      <= S_ADDR;
                  end
               end

               S_ADDR: begin
                  if (rx_vld) begin
                     addr      <= (addr << 8) | ADDR_W'(rx_data);
                     abyte_cnt <= abyte_cnt + 1'b1;
                     if (abyte_cnt == 2'(ADDR_BYTES - 1))
                        state <= S_LEN;
                  end
               end

               S_LEN: begin
                  if (rx_vld) begin
                     remain <= rx_data;
                     state  <= write_mode ? S_WDATA : S_RREQ;
                  end
               end

               S_WDATA: begin
                  if (rx_vld) begin
                     fx_wr    <= 1'b1;
                     fx_data  <= rx_data;
                     fx_waddr <= addr;
                     addr     <= addr + 1'b1;
                     if (remain == 8'd0)
                        state <= S_WACK;
                     else
                        remain <= remain - 1'b1;
                  end
               end

               S_WACK: begin
                  if (tx_ok) begin
                     tx_vld   <= 1'b1;
                     tx_data  <= ACK_BYTE;
                     cmd_done <= 1'b1;
                     state    <= S_IDLE;
                  end
               end

               S_RREQ: begin
                  fx_rd    <= 1'b1;
                  fx_raddr <= addr;
                  lat_cnt  <= '0;
                  state    <= S_RWAIT;
               end

               S_RWAIT: begin
                  // lat_cnt is 0 in the fx_rd cycle itself, so this samples RD_LAT cycles later.
                  if (lat_cnt == 3'(RD_LAT)) begin
                     rd_byte <= fx_q;
                     state   <= S_RSEND;
                  end else begin
                     lat_cnt <= lat_cnt + 1'b1;
                  end
               end

               S_RSEND: begin
                  if (tx_ok) begin
                     tx_vld  <= 1'b1;
                     tx_data <= rd_byte;
                     addr    <= addr + 1'b1;
                     if (remain == 8'd0) begin
                        cmd_done <= 1'b1;
                        state    <= S_IDLE;
                     end else begin
                        remain <= remain - 1'b1;
                        state  <= S_RREQ;
                     end
                  end
               end

               S_NAK: begin
                  if (tx_ok) begin
                     tx_vld  <= 1'b1;
                     tx_data <= NAK_BYTE;
                     state   <= S_IDLE;
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_commu_bridge.sv
// Self-checking bench for commu_bridge: table-driven frames plus hand-written
// sequences for timeout, junk/pacing and mid-command reset.
module tb_commu_bridge;

   localparam int TB_RD_LAT = 2;

   logic        clk_sys = 1'b0;
   logic        rst = 1'b1;
   logic        pluse_us = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_vld = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_vld;
   logic        tx_busy = 1'b0;
   logic [31:0] fx_waddr;
   logic        fx_wr;
   logic [7:0]  fx_data;
   logic        fx_rd;
   logic [31:0] fx_raddr;
   logic [7:0]  fx_q;
   logic        timeout_err;
   logic        cmd_done;

   commu_bridge #(
      .ADDR_BYTES (4),
      .RD_LAT     (TB_RD_LAT),
      .TIMEOUT_US (5),
      .WR_HDR     (8'hA5),
      .RD_HDR     (8'h5A)
   ) dut (
      .clk_sys     (clk_sys),
      .rst         (rst),
      .pluse_us    (pluse_us),
      .rx_data     (rx_data),
      .rx_vld      (rx_vld),
      .tx_data     (tx_data),
      .tx_vld      (tx_vld),
      .tx_busy     (tx_busy),
      .fx_waddr    (fx_waddr),
      .fx_wr       (fx_wr),
      .fx_data     (fx_data),
      .fx_rd       (fx_rd),
      .fx_raddr    (fx_raddr),
      .fx_q        (fx_q),
      .timeout_err (timeout_err),
      .cmd_done    (cmd_done)
   );

   always #5 clk_sys = ~clk_sys;

   // fx slave: data is valid only in the cycle exactly TB_RD_LAT after the fx_rd cycle.
   logic       pipe_v [TB_RD_LAT];
   logic [7:0] pipe_d [TB_RD_LAT];
   initial for (int i = 0; i < TB_RD_LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = 8'h00; end
   always @(posedge clk_sys) begin
      pipe_v[0] <= fx_rd;
      pipe_d[0] <= fx_raddr[7:0] ^ 8'hFF;
      for (int i = 1; i < TB_RD_LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_d[i] <= pipe_d[i-1];
      end
   end
   assign fx_q = pipe_v[TB_RD_LAT-1] ? pipe_d[TB_RD_LAT-1] : 8'hEE;

   // Event monitor, sampled on the falling edge.
   logic [31:0] wr_a_q [$];
   logic [7:0]  wr_d_q [$];
   logic [31:0] rd_a_q [$];
   logic [7:0]  tx_q   [$];
   int done_cnt = 0, to_pulses = 0, overlap = 0, space_viol = 0;
   int cyc = 0, last_tx = -10;

   always @(negedge clk_sys) begin
      cyc++;
      if (!rst) begin
         if (fx_wr) begin wr_a_q.push_back(fx_waddr); wr_d_q.push_back(fx_data); end
         if (fx_rd) rd_a_q.push_back(fx_raddr);
         if (fx_wr && fx_rd) overlap++;
         if (tx_vld) begin
            tx_q.push_back(tx_data);
            if (cyc - last_tx < 2) space_viol++;
            last_tx = cyc;
         end
         if (cmd_done) done_cnt++;
         if (timeout_err) to_pulses++;
      end
   end

   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      wr_a_q.delete(); wr_d_q.delete(); rd_a_q.delete(); tx_q.delete();
      done_cnt = 0; to_pulses = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic tick = 1'b0);
      @(negedge clk_sys);
      rx_data  = b;
      rx_vld   = 1'b1;
      pluse_us = tick;
      @(negedge clk_sys);
      rx_vld   = 1'b0;
      pluse_us = 1'b0;
   endtask

   task automatic tick_us(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys); pluse_us = 1'b1;
         @(negedge clk_sys); pluse_us = 1'b0;
      end
   endtask

   typedef struct {
      string              name;
      int                 nbytes;
      logic [0:11][7:0]   bytes;
      int                 n_wr;
      logic [0:3][31:0]   wa;
      logic [0:3][7:0]    wd;
      int                 n_rd;
      logic [0:3][31:0]   ra;
      int                 n_tx;
      logic [0:3][7:0]    txb;
   } vec_t;

   vec_t tbl [5];

   task automatic run_vec(input vec_t v);
      clear_mon();
      for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[i]);
      for (int b = 0; b < 300 && done_cnt == 0; b++) @(negedge clk_sys);
      repeat (6) @(negedge clk_sys);
      check({v.name, ".done"},    done_cnt, 1);
      check({v.name, ".timeout"}, to_pulses, 0);
      check({v.name, ".n_wr"},    wr_a_q.size(), v.n_wr);
      for (int i = 0; i < v.n_wr; i++) begin
         check($sformatf("%s.wr_addr%0d", v.name, i), (i < wr_a_q.size()) ? wr_a_q[i] : 32'hx, v.wa[i]);
         check($sformatf("%s.wr_data%0d", v.name, i), (i < wr_d_q.size()) ? 32'(wr_d_q[i]) : 32'hx, 32'(v.wd[i]));
      end
      check({v.name, ".n_rd"}, rd_a_q.size(), v.n_rd);
      for (int i = 0; i < v.n_rd; i++)
         check($sformatf("%s.rd_addr%0d", v.name, i), (i < rd_a_q.size()) ? rd_a_q[i] : 32'hx, v.ra[i]);
      check({v.name, ".n_tx"}, tx_q.size(), v.n_tx);
      for (int i = 0; i < v.n_tx; i++)
         check($sformatf("%s.tx%0d", v.name, i), (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hx, 32'(v.txb[i]));
   endtask

   initial begin
      tbl[0] = '{"wr_burst", 9,
                 {8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00},
                 3, {32'h0000_1000, 32'h0000_1001, 32'h0000_1002, 32'h0}, {8'h11, 8'h22, 8'h33, 8'h00},
                 0, {32'h0, 32'h0, 32'h0, 32'h0},
                 1, {8'h06, 8'h00, 8'h00, 8'h00}};
      tbl[1] = '{"rd_burst", 6,
                 {8'h5A, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 0, {32'h0, 32'h0, 32'h0, 32'h0}, {8'h00, 8'h00, 8'h00, 8'h00},
                 2, {32'h0000_00FE, 32'h0000_00FF, 32'h0, 32'h0},
                 2, {8'h01, 8'h00, 8'h00, 8'h00}};
      tbl[2] = '{"wr_wrap", 8,
                 {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00},
                 2, {32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0}, {8'hAA, 8'hBB, 8'h00, 8'h00},
                 0, {32'h0, 32'h0, 32'h0, 32'h0},
                 1, {8'h06, 8'h00, 8'h00, 8'h00}};
      tbl[3] = '{"rd_wrap", 6,
                 {8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 0, {32'h0, 32'h0, 32'h0, 32'h0}, {8'h00, 8'h00, 8'h00, 8'h00},
                 2, {32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 32'h0},
                 2, {8'h00, 8'hFF, 8'h00, 8'h00}};
      tbl[4] = '{"wr_single", 7,
                 {8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h9C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 1, {32'h1234_5678, 32'h0, 32'h0, 32'h0}, {8'h9C, 8'h00, 8'h00, 8'h00},
                 0, {32'h0, 32'h0, 32'h0, 32'h0},
                 1, {8'h06, 8'h00, 8'h00, 8'h00}};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("rst.fx_waddr", fx_waddr, 32'h0);
      check("rst.fx_raddr", fx_raddr, 32'h0);
      check("rst.strobes", {11'h0, tx_vld, tx_data, fx_wr, fx_data, fx_rd, timeout_err, cmd_done}, 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk_sys);

      for (int k = 0; k < 5; k++) run_vec(tbl[k]);

      // Timeout, including a byte arriving in the same cycle as a tick
      clear_mon();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      tick_us(4);
      send_byte(8'h00, 1'b1);
      tick_us(4);
      repeat (3) @(negedge clk_sys);
      check("to.no_early_pulse", to_pulses, 0);
      tick_us(1);
      for (int b = 0; b < 20 && tx_q.size() == 0; b++) @(negedge clk_sys);
      repeat (3) @(negedge clk_sys);
      check("to.pulses", to_pulses, 1);
      check("to.n_tx", tx_q.size(), 1);
      check("to.nak", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hx, 32'h15);
      check("to.n_wr", wr_a_q.size(), 0);
      check("to.done", done_cnt, 0);
      run_vec(tbl[0]);

      // Junk bytes, then a one-byte read held off by tx_busy
      clear_mon();
      tx_busy = 1'b1;
      send_byte(8'h00); send_byte(8'hFF);
      send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h10); send_byte(8'h00);
      repeat (50) @(negedge clk_sys);
      check("busy.tx_held", tx_q.size(), 0);
      check("busy.n_rd", rd_a_q.size(), 1);
      tx_busy = 1'b0;
      for (int b = 0; b < 20 && done_cnt == 0; b++) @(negedge clk_sys);
      repeat (10) @(negedge clk_sys);
      check("busy.n_tx", tx_q.size(), 1);
      check("busy.tx0", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hx, 32'hEF);
      check("busy.rd_addr", (rd_a_q.size() > 0) ? rd_a_q[0] : 32'hx, 32'h0000_0010);
      check("busy.done", done_cnt, 1);
      check("busy.n_wr", wr_a_q.size(), 0);

      // Reset in the middle of a 4-byte write burst
      clear_mon();
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h00); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
      repeat (3) @(negedge clk_sys);
      check("rstmid.n_wr", wr_a_q.size(), 2);
      rst = 1'b1;
      @(negedge clk_sys);
      check("rstmid.fx_waddr", fx_waddr, 32'h0);
      check("rstmid.fx_raddr", fx_raddr, 32'h0);
      check("rstmid.strobes", {11'h0, tx_vld, tx_data, fx_wr, fx_data, fx_rd, timeout_err, cmd_done}, 32'h0);
      @(negedge clk_sys);
      rst = 1'b0;
      send_byte(8'h03); send_byte(8'h04);
      repeat (20) @(negedge clk_sys);
      check("rstmid.no_ack", tx_q.size(), 0);
      check("rstmid.no_done", done_cnt, 0);
      check("rstmid.no_more_wr", wr_a_q.size(), 2);
      run_vec(tbl[2]);

      check("fx_wr_rd_exclusive", overlap, 0);
      check("tx_spacing", space_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
